// File: rtl/demux_1_to_4_6_bit_reg.sv
// Write-side demux: routes one WIDTH-bit value into one of four holding
// registers, with addressed, sequential (auto-increment) and clear-sweep writes.
module demux_1_to_4_6_bit_reg #(
   parameter int unsigned       WIDTH   = 6,
   parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       sel,
   input  logic             in_valid,
   input  logic             seq,
   input  logic             clr,
   output logic             in_ready,
   output logic             busy,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       written,
   output logic [1:0]       ptr
);

   localparam int unsigned NREG = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t           state;
   logic [1:0]       cnt;
   logic [1:0]       tgt;
   logic [WIDTH-1:0] regs [NREG];

   // A clear request blocks the write in the same cycle.
   assign in_ready = (state == IDLE) && !clr;
   assign busy     = (state == CLEAR);
   assign tgt      = seq ? ptr : sel;

   assign out0 = regs[0];
   assign out1 = regs[1];
   assign out2 = regs[2];
   assign out3 = regs[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         ptr     <= 2'd0;
         written <= 4'b0000;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= CLR_VAL;
         end
      end else begin
         case (state)
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  cnt   <= 2'd0;
                  ptr   <= 2'd0;
               end else if (in_valid) begin
                  regs[tgt]    <= in_data;
                  written[tgt] <= 1'b1;
                  if (seq) begin
                     ptr <= ptr + 2'd1;
                  end
               end
            end
            CLEAR: begin
               // One register per cycle so each mux input stays coherent.
               regs[cnt]    <= CLR_VAL;
               written[cnt] <= 1'b0;
               cnt          <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_demux_1_to_4_6_bit_reg.sv
// Scoreboarded bench for demux_1_to_4_6_bit_reg: a reference model pushes the
// expected post-edge state each cycle, which is popped and compared after the edge.
module tb_demux_1_to_4_6_bit_reg;

   localparam int unsigned WIDTH = 6;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       sel;
   logic             in_valid;
   logic             seq;
   logic             clr;
   logic             in_ready;
   logic             busy;
   logic [WIDTH-1:0] out0, out1, out2, out3;
   logic [3:0]       written;
   logic [1:0]       ptr;

   demux_1_to_4_6_bit_reg #(.WIDTH(WIDTH), .CLR_VAL(6'b000000)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .sel(sel), .in_valid(in_valid),
      .seq(seq), .clr(clr), .in_ready(in_ready), .busy(busy),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .written(written), .ptr(ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][WIDTH-1:0] o;
      logic [3:0]            wr;
      logic [1:0]            p;
      logic                  bsy;
   } snap_t;

   snap_t sb_q[$];

   int n_vec  = 0;
   int n_err  = 0;
   int busy_cnt = 0;

   // Reference model state
   bit                    m_known = 0;
   bit                    m_clear = 0;
   logic [1:0]            m_cnt   = '0;
   logic [3:0][WIDTH-1:0] m_regs  = '0;
   logic [3:0]            m_wr    = '0;
   logic [1:0]            m_ptr   = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] mux4(input logic [1:0] s);
      case (s)
         2'd0: return out0;
         2'd1: return out1;
         2'd2: return out2;
         default: return out3;
      endcase
   endfunction

   // Advance the model one edge, push expectation, then compare after the edge.
   task automatic cycle();
      snap_t exp, act;
      logic [1:0] t;
      @(negedge clk);
      if (m_known) begin
         check("in_ready", 32'(in_ready), 32'(!m_clear && !clr));
         check("busy_pre", 32'(busy), 32'(m_clear));
      end
      if (busy === 1'b1) busy_cnt++;
      if (rst) begin
         m_known = 1; m_clear = 0; m_cnt = '0; m_regs = '0; m_wr = '0; m_ptr = '0;
      end else if (m_known && !m_clear) begin
         if (clr) begin
            m_clear = 1; m_cnt = '0; m_ptr = '0;
         end else if (in_valid) begin
            t = seq ? m_ptr : sel;
            m_regs[t] = in_data;
            m_wr[t]   = 1'b1;
            if (seq) m_ptr = m_ptr + 2'd1;
         end
      end else if (m_known) begin
         m_regs[m_cnt] = '0;
         m_wr[m_cnt]   = 1'b0;
         if (m_cnt == 2'd3) m_clear = 0;
         m_cnt = m_cnt + 2'd1;
      end
      exp.o = m_regs; exp.wr = m_wr; exp.p = m_ptr; exp.bsy = m_clear;
      if (m_known) sb_q.push_back(exp);
      @(posedge clk);
      #1;
      if (m_known) begin
         exp = sb_q.pop_front();
         act.o = {out3, out2, out1, out0};
         act.wr = written; act.p = ptr; act.bsy = busy;
         check("outs", 32'(act.o), 32'(exp.o));
         check("written", 32'(act.wr), 32'(exp.wr));
         check("ptr", 32'(act.p), 32'(exp.p));
         check("busy", 32'(act.bsy), 32'(exp.bsy));
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic s, input logic c,
                        input logic [1:0] a, input logic [WIDTH-1:0] d);
      rst = r; in_valid = v; seq = s; clr = c; sel = a; in_data = d;
      cycle();
   endtask

   initial begin
      rst = 0; in_valid = 0; seq = 0; clr = 0; sel = '0; in_data = '0;

      // Reset with a write pending: reset wins
      drive(1, 1, 0, 0, 2'd0, 6'h3F);
      drive(1, 1, 0, 0, 2'd0, 6'h3F);
      drive(0, 0, 0, 0, 2'd0, 6'h00);
      check("rst_outs", 32'({out3, out2, out1, out0}), 32'h0);
      check("rst_written", 32'(written), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h1);

      // Addressed writes
      for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 2'(i), 6'(i));
      drive(0, 0, 0, 0, 2'd0, 6'h00);
      for (int i = 0; i < 4; i++) check("mux_read", 32'(mux4(2'(i))), 32'(i));
      check("addr_written", 32'(written), 32'hF);
      check("addr_ptr", 32'(ptr), 32'h0);

      // Sequential writes with wrap; sel held at 3 must be ignored
      drive(0, 1, 1, 0, 2'd3, 6'h2A);
      drive(0, 1, 1, 0, 2'd3, 6'h15);
      drive(0, 1, 1, 0, 2'd3, 6'h3F);
      drive(0, 1, 1, 0, 2'd3, 6'h01);
      drive(0, 1, 1, 0, 2'd3, 6'h10);
      check("seq_out0", 32'(out0), 32'h10);
      check("seq_out1", 32'(out1), 32'h15);
      check("seq_out2", 32'(out2), 32'h3F);
      check("seq_out3", 32'(out3), 32'h01);
      check("seq_ptr", 32'(ptr), 32'h1);

      // Clear with simultaneous write, then stall the write across the sweep
      busy_cnt = 0;
      drive(0, 1, 0, 1, 2'd2, 6'h07);
      check("clr_ptr", 32'(ptr), 32'h0);
      check("clr_out2_kept", 32'(out2), 32'h3F);
      for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 2'd2, 6'h07);
      check("sweep_busy_cycles", 32'(busy_cnt), 32'd4);
      check("stall_out2", 32'(out2), 32'h07);
      check("stall_written", 32'(written), 32'b0100);
      check("stall_out0", 32'(out0), 32'h0);
      drive(0, 0, 0, 0, 2'd0, 6'h00);

      // Reset on the second clear-sweep cycle
      drive(0, 1, 1, 0, 2'd0, 6'h11);
      drive(0, 0, 0, 1, 2'd0, 6'h00);
      drive(0, 0, 0, 0, 2'd0, 6'h00);
      drive(1, 1, 0, 1, 2'd1, 6'h22);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_outs", 32'({out3, out2, out1, out0}), 32'h0);
      check("midrst_written", 32'(written), 32'h0);
      check("midrst_ptr", 32'(ptr), 32'h0);
      drive(0, 0, 0, 0, 2'd0, 6'h00);

      // Random traffic against the model
      for (int i = 0; i < 200; i++) begin
         drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 9) == 0), 2'($urandom), 6'($urandom));
      end

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
